// File: rtl/riscv_pkg.sv
// Shared widths and constants for the integer register file.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port: index decode, x0 forcing, optional write-first bypass.
// Bypass is compiled in when REGFILE_BYPASS_EN is defined; otherwise the port is read-first.
module reg_file_rdport
  import riscv_pkg::*;
(
  input  logic                           i_rst_n,
  input  reg_idx_t                       i_addr,
  input  logic [NUM_REGS-1:0][XLEN-1:0]  i_regs,
  input  logic                           i_we,
  input  reg_idx_t                       i_waddr,
  input  word_t                          i_wdata,
  output word_t                          o_rdata
);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    o_rdata = i_regs[i_addr];
    if (i_we && (i_waddr == i_addr))
      o_rdata = i_wdata;
    // x0 and the reset cycle always win over bypassed data
    if ((i_addr == ZERO_REG) || !i_rst_n)
      o_rdata = '0;
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, i_we, i_waddr, i_wdata};

  always_comb begin
    o_rdata = i_regs[i_addr];
    if ((i_addr == ZERO_REG) || !i_rst_n)
      o_rdata = '0;
  end
`endif

endmodule

// File: rtl/reg_file.sv
// 31x32 register file (x0 hardwired to zero), two combinational read ports, one write port.
// Define REGFILE_BYPASS_EN for write-first same-cycle reads; default is read-first.
module reg_file
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] A1,
  input  logic [REG_ADDR_W-1:0] A2,
  input  logic [REG_ADDR_W-1:0] A3,
  input  logic [XLEN-1:0]       WD3,
  input  logic                  WE3,
  output logic [XLEN-1:0]       RD1,
  output logic [XLEN-1:0]       RD2
);

  word_t                          r_regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0][XLEN-1:0]  w_regs;

  assign w_regs[0] = '0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_view
    assign w_regs[g] = r_regs[g];
  end

  // Index 0 has no slot, so a write to A3=0 matches nothing and is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (WE3 && (A3 == REG_ADDR_W'(i)))
          r_regs[i] <= WD3;
    end
  end

  reg_file_rdport u_rdport1 (
    .i_rst_n (rst_n),
    .i_addr  (A1),
    .i_regs  (w_regs),
    .i_we    (WE3),
    .i_waddr (A3),
    .i_wdata (WD3),
    .o_rdata (RD1)
  );

  reg_file_rdport u_rdport2 (
    .i_rst_n (rst_n),
    .i_addr  (A2),
    .i_regs  (w_regs),
    .i_we    (WE3),
    .i_waddr (A3),
    .i_wdata (WD3),
    .o_rdata (RD2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: array reference model, per-cycle compare, directed literal checks.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic        we3;
  logic [31:0] rd1, rd2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] model [0:31];

  always #5 clk = ~clk;

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A1    (a1),
    .A2    (a2),
    .A3    (a3),
    .WD3   (wd3),
    .WE3   (we3),
    .RD1   (rd1),
    .RD2   (rd2)
  );

  // Reference: what a port must show given the architectural state and current inputs.
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (!rst_n)                  return 32'h0;
    if (a == 5'd0)               return 32'h0;
    if (BYP && we3 && a3 == a)   return wd3;
    return model[a];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we3 && a3 != 5'd0) begin
      model[a3] = wd3;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (rd1 !== expect_rd(a1)) begin
        errors++;
        $display("FAIL model_rd1 t=%0t A1=%0d got=%h exp=%h", $time, a1, rd1, expect_rd(a1));
      end
      checks++;
      if (rd2 !== expect_rd(a2)) begin
        errors++;
        $display("FAIL model_rd2 t=%0t A2=%0d got=%h exp=%h", $time, a2, rd2, expect_rd(a2));
      end
    end
  end

  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    @(posedge clk);
    #1;
    rst_n = r; we3 = we; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b0; we3 = 1'b0; a3 = 5'd0; wd3 = 32'h0; a1 = 5'd0; a2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // reset clears a written register
    drive(1, 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    drive(1, 0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk); lit("x5_written", rd1, 32'hDEADBEEF);
    drive(0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk); lit("rd_in_reset", rd1, 32'h0);
    drive(1, 0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk); lit("x5_after_reset", rd1, 32'h0);

    // write then read on both ports
    drive(1, 1, 5'd7, 32'h12345678, 5'd0, 5'd0);
    drive(1, 0, 5'd0, 32'h0, 5'd7, 5'd7);
    @(negedge clk); lit("x7_rd1", rd1, 32'h12345678);
    lit("x7_rd2", rd2, 32'h12345678);

    // x0 ignores writes, never bypasses
    drive(1, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    @(negedge clk); lit("x0_during_write", rd1, 32'h0);
    drive(1, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk); lit("x0_after_write", rd1, 32'h0);
    lit("x0_rd2", rd2, 32'h0);

    // same-cycle read/write hazard
    drive(1, 1, 5'd3, 32'h00000011, 5'd0, 5'd0);
    drive(1, 1, 5'd3, 32'h00000022, 5'd3, 5'd3);
    @(negedge clk); lit("hazard_rd1", rd1, BYP ? 32'h00000022 : 32'h00000011);
    lit("hazard_rd2", rd2, BYP ? 32'h00000022 : 32'h00000011);
    drive(1, 0, 5'd0, 32'h0, 5'd3, 5'd3);
    @(negedge clk); lit("hazard_after", rd1, 32'h00000022);

    // reset beats a simultaneous write
    drive(1, 1, 5'd9, 32'h00000077, 5'd0, 5'd0);
    drive(0, 1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
    @(negedge clk); lit("rst_vs_wr_cycle", rd1, 32'h0);
    drive(1, 0, 5'd0, 32'h0, 5'd9, 5'd9);
    @(negedge clk); lit("rst_vs_wr_after", rd1, 32'h0);

    // full sweep
    for (int i = 1; i < 32; i++)
      drive(1, 1, 5'(i), 32'h100 + 32'(i), 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      @(negedge clk);
      lit("sweep_rd1", rd1, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
      lit("sweep_rd2", rd2, (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i));
    end

    // random traffic, with reads often aimed at the write index
    for (int n = 0; n < 3000; n++) begin
      logic        r, we;
      logic [4:0]  wa, ra1, ra2;
      logic [31:0] wd;
      r   = ($urandom_range(0, 49) != 0);
      we  = ($urandom_range(0, 2) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(r, we, wa, wd, ra1, ra2);
    end

    drive(1, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and address width at 5 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 A1  input  5  read port 1 register index (rs1), drives RD1.
REQ-005 A2  input  5  read port 2 register index (rs2), drives RD2.
REQ-006 A3  input  5  write port register index (rd).
REQ-007 WD3  input  32  write data (ALU result or load data).
REQ-008 WE3  input  1  write enable, active-high.
REQ-009 RD1  output  32  read data 1; feeds ALU SrcA.
REQ-010 RD2  output  32  read data 2; feeds the ALU SrcB mux and store data.

Function
REQ-011 Storage SHALL be 31 general registers x1..x31 of 32 bits; x0 SHALL have no storage.
REQ-012 Reads SHALL be combinational: RD1/RD2 reflect the addressed register in the same cycle, with zero clock latency.
REQ-013 Reads of index 0 SHALL return 32'h00000000 on either port, regardless of any write.
REQ-014 On a rising clk with rst_n=1, WE3=1 and A3!=0, register A3 SHALL take WD3; the new value SHALL be visible on reads from the following cycle.
REQ-015 Writes with WE3=1 and A3=0 SHALL be discarded with no side effect.
REQ-016 With WE3=0, no register SHALL change.
REQ-017 A1==A2 SHALL return identical data on both ports.
REQ-018 Read and write of the same index in one cycle SHALL follow REQ-030/REQ-031.
REQ-019 X or out-of-range values SHALL be impossible, since 5-bit indices cover exactly x0..x31.

Reset
REQ-020 While rst_n=0 at a rising clk, x1..x31 SHALL all be cleared to 32'h00000000 in that single edge.
REQ-021 Reset SHALL take priority over a simultaneous write; a write presented in the reset cycle SHALL be lost.
REQ-022 During and after reset, RD1/RD2 SHALL read 0 for every index until the first post-reset write.
REQ-023 Reset asserted mid-program SHALL clear all registers at the next edge, with no partial state retained.

Configuration
REQ-030 With REGFILE_BYPASS_EN defined: when WE3=1, A3!=0 and A3 equals A1 (or A2), RD1 (or RD2) SHALL return WD3 combinationally in the same cycle (write-first).
REQ-031 Without REGFILE_BYPASS_EN: in the situation of REQ-030, the port SHALL return the pre-write stored value (read-first); WD3 appears from the next cycle.
REQ-032 Bypass SHALL never apply to index 0, and SHALL be suppressed while rst_n=0 (ports read 0 in the reset cycle).

Structure
REQ-040 Shared package riscv_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and ZERO_REG=5'd0; reg_file SHALL use them for all widths.
REQ-041 The read path SHALL be one small sub-module reg_file_rdport (index decode, x0 forcing, optional bypass), instantiated twice.
REQ-042 Register storage and write/reset logic SHALL remain in reg_file.

Verification
REQ-050 Reset: hold rst_n=0 for one edge after writing x5=32'hDEADBEEF -> RD1 with A1=5 reads 32'h00000000.
REQ-051 Write/read: WE3=1, A3=7, WD3=32'h12345678, one edge, then A1=7, A2=7 -> RD1=RD2=32'h12345678.
REQ-052 x0: WE3=1, A3=0, WD3=32'hFFFFFFFF, one edge, then A1=0 -> RD1=32'h00000000.
REQ-053 Same-cycle hazard: x3 holds 32'h00000011; drive WE3=1, A3=3, WD3=32'h00000022, A1=3 before the edge -> RD1=32'h00000022 with REGFILE_BYPASS_EN, 32'h00000011 without; after the edge, 32'h00000022 in both builds.
REQ-054 Reset vs write: rst_n=0, WE3=1, A3=9, WD3=32'hCAFEF00D at the same edge -> x9 reads 32'h00000000 afterwards.
REQ-055 Sweep: write x1..x31 with value equal to 32'h100+index, then read all pairs (A1=i, A2=31-i) -> each port returns 32'h100+index, or 0 for index 0.
